spi_xfer_arbiter: RTL and testbench

- Shares one SPI master control port (toXmit/strobe/ss in; Rcvd/Ready/XmitFull out) among NREQ requesters.
- Round-robin arbitration; one byte transfer outstanding at a time.
- Sequences strobe issue, waits for Ready with a timeout, and routes Rcvd back to the granted requester.
- Sits between system-side clients and the SPI master controller.

---
 rtl/spi_xfer_arbiter_pkg.sv | 42 ++++
 rtl/spi_xfer_arbiter_if.sv | 37 +++
 rtl/spi_rr_arbiter.sv | 25 ++
 rtl/spi_xfer_arbiter.sv | 109 ++++++++++
 tb/tb_spi_xfer_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_xfer_arbiter_pkg.sv
// Shared types and helpers for the SPI transfer arbiter.
//   state_t  : arbiter FSM states
//   pick_t   : round-robin pick result (found flag + winning id)
//   rr_pick  : first set request bit at or above the pointer, wrapping at n
package spi_arb_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned SS_W    = 2;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned ID_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] id;
  } pick_t;

  // Only the low n request bits take part; ptr is always below n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [ID_W-1:0]    ptr,
                                    input int unsigned        n);
    pick_t       r;
    int unsigned idx;
    r = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !r.found && req[idx[ID_W-1:0]]) begin
        r.found = 1'b1;
        r.id    = idx[ID_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Client + SPI-master-control bundle of the transfer arbiter.
//   req/req_data/req_ss      : per-requester request, byte and slave select
//   ack/rsp_valid            : one-hot grant and completion pulses
//   rsp_data/rsp_err/busy    : response byte, timeout flag, arbiter busy
//   m_toXmit/m_strobe/m_ss   : control toward the SPI master
//   m_Rcvd/m_Ready/m_XmitFull: status from the SPI master
// The slave modport is the arbiter; the master modport is the
// client-and-SPI-master side around it.
interface spi_xfer_arbiter_if #(parameter int unsigned NREQ = 2);
  import spi_arb_pkg::*;

  logic [NREQ-1:0]             req;
  logic [NREQ-1:0][BYTE_W-1:0] req_data;
  logic [NREQ-1:0][SS_W-1:0]   req_ss;
  logic [NREQ-1:0]             ack;
  logic [NREQ-1:0]             rsp_valid;
  logic [BYTE_W-1:0]           rsp_data;
  logic                        rsp_err;
  logic                        busy;
  logic [BYTE_W-1:0]           m_toXmit;
  logic                        m_strobe;
  logic [SS_W-1:0]             m_ss;
  logic [BYTE_W-1:0]           m_Rcvd;
  logic                        m_Ready;
  logic                        m_XmitFull;

  modport slave (
    input  req, req_data, req_ss, m_Rcvd, m_Ready, m_XmitFull,
    output ack, rsp_valid, rsp_data, rsp_err, busy, m_toXmit, m_strobe, m_ss
  );

  modport master (
    output req, req_data, req_ss, m_Rcvd, m_Ready, m_XmitFull,
    input  ack, rsp_valid, rsp_data, rsp_err, busy, m_toXmit, m_strobe, m_ss
  );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker; the pointer register lives in the parent.
//   req   : request vector
//   ptr   : search start position
//   found : any request present
//   id    : winning requester
module spi_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] id
);

  pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(req), ID_W'(ptr), NREQ);
    found = pick.found;
    id    = pick.id[$clog2(NREQ)-1:0];
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master control port among NREQ requesters, one byte at a time.
//   clk   : system clock
//   n_rst : asynchronous active-low reset
//   bus   : client request/response and SPI master control (slave modport)
// Flow: IDLE grant -> ISSUE strobe -> WAIT for Ready or timeout -> RESP pulse.
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TW      = 11
) (
  input  logic               clk,
  input  logic               n_rst,
  spi_xfer_arbiter_if.slave  bus
);

  localparam int unsigned   IDW     = $clog2(NREQ);
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  state_t          state;
  state_t          next_state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  pick_id;
  logic            pick_found;
  logic [TW-1:0]   cnt;
  logic            strobe;
  logic            to_hit;

  spi_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (bus.req),
    .ptr   (ptr),
    .found (pick_found),
    .id    (pick_id)
  );

  // Last allowed WAIT cycle without Ready; TIMEOUT of 0 waits forever.
  assign to_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Next state and the combinational strobe.
  always_comb begin
    next_state = state;
    strobe     = 1'b0;
    case (state)
      IDLE:  if (pick_found) next_state = ISSUE;
      ISSUE: if (!bus.m_XmitFull) begin
               strobe     = 1'b1;
               next_state = WAIT;
             end
      WAIT:  if (bus.m_Ready || to_hit) next_state = RESP;
      RESP:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign bus.m_strobe = strobe;

  // Grant latch, timeout counter, response capture and RR pointer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr           <= '0;
      id_q          <= '0;
      cnt           <= '0;
      bus.ack       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.m_toXmit  <= '0;
      bus.m_ss      <= '0;
    end else begin
      bus.ack       <= '0;
      bus.rsp_valid <= '0;
      bus.busy      <= (next_state != IDLE);
      case (state)
        IDLE: if (pick_found) begin
          id_q         <= pick_id;
          bus.m_toXmit <= bus.req_data[pick_id];
          bus.m_ss     <= bus.req_ss[pick_id];
          bus.ack      <= NREQ'(1) << pick_id;
        end
        ISSUE: if (strobe) cnt <= '0;
        WAIT: begin
          if (bus.m_Ready) begin
            bus.rsp_data  <= bus.m_Rcvd;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= NREQ'(1) << id_q;
          end else if (to_hit) begin
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= NREQ'(1) << id_q;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: ptr <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter: a cycle table for single-request and
// backpressure timing, then hand sequences for timeout, early Ready with a
// dropped request, reset during WAIT, and round-robin contention.
module tb_spi_xfer_arbiter;
  import spi_arb_pkg::*;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned TW      = 5;

  logic clk;
  logic n_rst;

  spi_xfer_arbiter_if #(.NREQ(NREQ)) bus ();

  spi_xfer_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [1:0] req;
    logic       rdy;
    logic       full;
    logic [7:0] rcvd;
    logic [1:0] ack;
    logic [1:0] rv;
    logic       stb;
    logic       busy;
    logic [7:0] tx;
    logic [1:0] ss;
    logic [7:0] rdata;
    logic       rerr;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic [1:0] req, input logic rdy, input logic full,
                              input logic [7:0] rcvd, input logic [1:0] ack,
                              input logic [1:0] rv, input logic stb, input logic busy,
                              input logic [7:0] tx, input logic [1:0] ss,
                              input logic [7:0] rdata, input logic rerr);
    vec_t v;
    v.req = req; v.rdy = rdy; v.full = full; v.rcvd = rcvd;
    v.ack = ack; v.rv = rv; v.stb = stb; v.busy = busy;
    v.tx = tx; v.ss = ss; v.rdata = rdata; v.rerr = rerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output bit ok);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (bus.ack == '0 && n < 12);
    ok = (bus.ack != '0);
    chk("ack_wait", 32'(ok), 32'd1);
  endtask

  // One transfer: grant check, optional early Ready in the strobe cycle,
  // Ready dly cycles after the strobe, then response and return to IDLE.
  task automatic do_xfer(input logic [1:0] exp_oh, input logic [7:0] exp_tx,
                         input logic [1:0] exp_ss, input int dly,
                         input logic [7:0] rcvd, input bit drop, input bit early);
    bit ok;
    wait_ack(ok);
    chk("xfer.ack",    32'(bus.ack),      32'(exp_oh));
    chk("xfer.strobe", 32'(bus.m_strobe), 32'd1);
    chk("xfer.tx",     32'(bus.m_toXmit), 32'(exp_tx));
    chk("xfer.ss",     32'(bus.m_ss),     32'(exp_ss));
    chk("xfer.busy",   32'(bus.busy),     32'd1);
    if (drop) bus.req = bus.req & ~exp_oh;
    bus.m_Ready = early;
    bus.m_Rcvd  = 8'hEE;
    for (int k = 1; k <= dly; k++) begin
      cyc();
      chk("xfer.no_rv", 32'(bus.rsp_valid), 32'd0);
      bus.m_Ready = (k == dly);
      bus.m_Rcvd  = (k == dly) ? rcvd : 8'hEE;
    end
    cyc();
    bus.m_Ready = 1'b0;
    chk("xfer.rv",    32'(bus.rsp_valid), 32'(exp_oh));
    chk("xfer.rdata", 32'(bus.rsp_data),  32'(rcvd));
    chk("xfer.rerr",  32'(bus.rsp_err),   32'd0);
    cyc();
    chk("xfer.rv_end", 32'(bus.rsp_valid), 32'd0);
    chk("xfer.idle",   32'(bus.busy),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;

    // Single request (A5 -> 3C), then requester 1 under 6 cycles of XmitFull.
    tbl[0]  = mk(2'b01, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 2'b00, 8'h00, 0);
    tbl[1]  = mk(2'b01, 0, 0, 8'h00, 2'b01, 2'b00, 1, 1, 8'hA5, 2'b01, 8'h00, 0);
    for (int i = 2; i <= 4; i++)
      tbl[i] = mk(2'b01, 0, 0, 8'h00, 2'b00, 2'b00, 0, 1, 8'hA5, 2'b01, 8'h00, 0);
    tbl[5]  = mk(2'b01, 1, 0, 8'h3C, 2'b00, 2'b00, 0, 1, 8'hA5, 2'b01, 8'h00, 0);
    tbl[6]  = mk(2'b00, 0, 0, 8'h00, 2'b00, 2'b01, 0, 1, 8'hA5, 2'b01, 8'h3C, 0);
    tbl[7]  = mk(2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0, 8'hA5, 2'b01, 8'h3C, 0);
    tbl[8]  = mk(2'b10, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0, 8'hA5, 2'b01, 8'h3C, 0);
    tbl[9]  = mk(2'b10, 0, 1, 8'h00, 2'b10, 2'b00, 0, 1, 8'h5A, 2'b10, 8'h3C, 0);
    for (int i = 10; i <= 14; i++)
      tbl[i] = mk(2'b10, 0, 1, 8'h00, 2'b00, 2'b00, 0, 1, 8'h5A, 2'b10, 8'h3C, 0);
    tbl[15] = mk(2'b10, 0, 0, 8'h00, 2'b00, 2'b00, 1, 1, 8'h5A, 2'b10, 8'h3C, 0);
    tbl[16] = mk(2'b10, 0, 0, 8'h00, 2'b00, 2'b00, 0, 1, 8'h5A, 2'b10, 8'h3C, 0);
    tbl[17] = mk(2'b10, 1, 0, 8'hC3, 2'b00, 2'b00, 0, 1, 8'h5A, 2'b10, 8'h3C, 0);
    tbl[18] = mk(2'b00, 0, 0, 8'h00, 2'b00, 2'b10, 0, 1, 8'h5A, 2'b10, 8'hC3, 0);
    tbl[19] = mk(2'b00, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0, 8'h5A, 2'b10, 8'hC3, 0);

    n_rst          = 1'b0;
    bus.req        = '0;
    bus.req_data   = {8'h5A, 8'hA5};
    bus.req_ss     = {2'b10, 2'b01};
    bus.m_Rcvd     = '0;
    bus.m_Ready    = 1'b0;
    bus.m_XmitFull = 1'b0;
    repeat (3) cyc();
    chk("rst.busy",  32'(bus.busy),      32'd0);
    chk("rst.ack",   32'(bus.ack),       32'd0);
    chk("rst.tx",    32'(bus.m_toXmit),  32'd0);
    chk("rst.rdata", 32'(bus.rsp_data),  32'd0);
    n_rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cyc();
      bus.req        = tbl[i].req;
      bus.m_Ready    = tbl[i].rdy;
      bus.m_XmitFull = tbl[i].full;
      bus.m_Rcvd     = tbl[i].rcvd;
      #1;
      chk($sformatf("vec%0d.ack", i),    32'(bus.ack),       32'(tbl[i].ack));
      chk($sformatf("vec%0d.rv", i),     32'(bus.rsp_valid), 32'(tbl[i].rv));
      chk($sformatf("vec%0d.strobe", i), 32'(bus.m_strobe),  32'(tbl[i].stb));
      chk($sformatf("vec%0d.busy", i),   32'(bus.busy),      32'(tbl[i].busy));
      chk($sformatf("vec%0d.tx", i),     32'(bus.m_toXmit),  32'(tbl[i].tx));
      chk($sformatf("vec%0d.ss", i),     32'(bus.m_ss),      32'(tbl[i].ss));
      chk($sformatf("vec%0d.rdata", i),  32'(bus.rsp_data),  32'(tbl[i].rdata));
      chk($sformatf("vec%0d.rerr", i),   32'(bus.rsp_err),   32'(tbl[i].rerr));
    end

    // Timeout: WAIT lasts TIMEOUT cycles, so rsp_valid lands TIMEOUT+1 after strobe.
    bus.m_Ready  = 1'b0;
    bus.req      = 2'b01;
    bus.req_data = {8'h99, 8'h77};
    bus.req_ss   = {2'b01, 2'b11};
    wait_ack(ok);
    chk("to.ack",    32'(bus.ack),      32'd1);
    chk("to.strobe", 32'(bus.m_strobe), 32'd1);
    chk("to.tx",     32'(bus.m_toXmit), 32'h77);
    bus.req = 2'b00;
    n = 0;
    do begin
      cyc();
      n++;
    end while (bus.rsp_valid == '0 && n < 40);
    chk("to.latency", 32'(n),             32'(TIMEOUT + 1));
    chk("to.rv",      32'(bus.rsp_valid), 32'd1);
    chk("to.rerr",    32'(bus.rsp_err),   32'd1);
    chk("to.rdata",   32'(bus.rsp_data),  32'd0);

    // Normal transfer after the timeout.
    bus.req = 2'b10;
    do_xfer(2'b10, 8'h99, 2'b01, 2, 8'h5E, 1, 0);

    // Ready during strobe is ignored; requester drops req after ack.
    bus.req_data = {8'h99, 8'h3D};
    bus.req_ss   = {2'b01, 2'b10};
    bus.req      = 2'b01;
    do_xfer(2'b01, 8'h3D, 2'b10, 3, 8'h6B, 1, 1);

    // Reset while in WAIT aborts the transfer without a response.
    bus.req_data = {8'hB7, 8'h42};
    bus.req      = 2'b01;
    wait_ack(ok);
    bus.req = 2'b00;
    cyc();
    cyc();
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid.ack",    32'(bus.ack),       32'd0);
    chk("mid.rv",     32'(bus.rsp_valid), 32'd0);
    chk("mid.rdata",  32'(bus.rsp_data),  32'd0);
    chk("mid.rerr",   32'(bus.rsp_err),   32'd0);
    chk("mid.busy",   32'(bus.busy),      32'd0);
    chk("mid.tx",     32'(bus.m_toXmit),  32'd0);
    chk("mid.ss",     32'(bus.m_ss),      32'd0);
    chk("mid.strobe", 32'(bus.m_strobe),  32'd0);
    bus.m_Ready = 1'b1;
    bus.m_Rcvd  = 8'h55;
    cyc();
    cyc();
    n_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("mid.no_rv", 32'(bus.rsp_valid), 32'd0);
    end
    bus.m_Ready = 1'b0;
    bus.req     = 2'b10;
    do_xfer(2'b10, 8'hB7, 2'b01, 2, 8'hA1, 1, 0);

    // Contention from reset: both held, grants alternate 0,1,0,1.
    n_rst        = 1'b0;
    bus.req      = 2'b11;
    bus.req_data = {8'h22, 8'h11};
    bus.req_ss   = {2'b10, 2'b01};
    cyc();
    cyc();
    n_rst = 1'b1;
    do_xfer(2'b01, 8'h11, 2'b01, 2, 8'hEE ^ 8'h11, 0, 0);
    do_xfer(2'b10, 8'h22, 2'b10, 2, 8'hEE ^ 8'h22, 0, 0);
    do_xfer(2'b01, 8'h11, 2'b01, 3, 8'hEE ^ 8'h33, 0, 0);
    do_xfer(2'b10, 8'h22, 2'b10, 2, 8'hEE ^ 8'h44, 0, 0);
    bus.req = 2'b00;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
